crc_check: RTL and testbench
============================

CRC_CHECK -- requirements
Module: crc_check

Interface
- REQ-001: clk  input  1  single clock; all state changes on posedge clk.
- REQ-002: rst_n  input  1  reset, asynchronous, active-low.
- REQ-003: s_in  input  1  received bit from the bit unstuffer; NRZI-decoded, SYNC already stripped, LSB-first.
- REQ-004: start  input  1  one-cycle pulse, coincident with the first PID bit on s_in.
- REQ-005: endr  input  1  one-cycle pulse on the cycle after the last packet bit; s_in is ignored on that cycle.
- REQ-006: pause  input  1  high = the unstuffer dropped a stuffed bit this cycle; s_in is invalid.
- REQ-007: pid  output  4  captured PID[3:0].
- REQ-008: pkt_type  output  2  packet type: 0 = data, 1 = token, 2 = handshake, 3 = invalid.
- REQ-009: d_out / d_valid  output  1/1  payload bit (non-PID, non-CRC) and its qualifier, forwarded to the receive FIFO.
- REQ-010: done  output  1  one-cycle pulse when the packet verdict is valid.
- REQ-011: pkt_ok  output  1  verdict; valid while done=1.
- REQ-012: err  output  3  error flags {len_err, crc_err, pid_err}; valid while done=1.

Function
- REQ-013: FSM states are IDLE, PID, BODY, CHECK; a bit is "accepted" in a cycle where the state is PID or BODY and pause=0 and endr=0.
- REQ-014: IDLE->PID on start, and the start-cycle bit is accepted as PID bit 0.
- REQ-015: PID captures 8 accepted bits into pid_sr[7:0] LSB-first; after the 8th, it goes to BODY, or to CHECK if endr arrives.
- REQ-016: pid_err = (pid_sr[7:4] != ~pid_sr[3:0]).
- REQ-017: pkt_type decode from pid_sr[1:0]: 01 = token (body 16 bits), 11 = data (body 80 bits), 10 = handshake (body 0), 00 = invalid (pid_err forced).
- REQ-018: BODY shifts each accepted bit into CRC5 (poly x^5+x^2+1) for token, or CRC16 (poly x^16+x^15+x^2+1) for data; both registers are preset to all ones on entering BODY.
- REQ-019: d_valid=1 and d_out=s_in, registered with one cycle of latency, for accepted body bits with index < 11 (token) or < 64 (data); CRC bits are never forwarded.
- REQ-020: A 7-bit body counter increments per accepted bit and saturates at 127.
- REQ-021: len_err = body count != the expected body length for pkt_type.
- REQ-022: crc_err is set when the final residue differs from 5'b01100 (token) or 16'h800D (data); it is always 0 for handshake packets and when len_err=1.
- REQ-023: endr in PID or BODY causes a transition to CHECK; CHECK asserts done for exactly one cycle, then goes to IDLE.
- REQ-024: pkt_ok = ~|err.
- REQ-025: endr in IDLE is ignored.
- REQ-026: start in PID, BODY, or CHECK aborts the current packet with no done, and restarts PID capture with the start-cycle bit.
- REQ-027: pause takes precedence over s_in: no shift, no count, no d_valid.
- REQ-028: pid, pkt_type, err, and pkt_ok hold their values until the next start.

Reset
- REQ-029: rst_n=0 asynchronously forces the state to IDLE, clears all counters and shift registers, and drives pid=0, pkt_type=3, d_out=0, d_valid=0, done=0, pkt_ok=0, err=0.
- REQ-030: Reset mid-packet discards the packet; no done is produced.

Configuration
- REQ-031: With CRC_ERR_CNT_EN defined, an output err_cnt[7:0] increments on each done with pkt_ok=0, saturates at 255, and resets to 0.
- REQ-032: Without CRC_ERR_CNT_EN, neither the err_cnt port nor its logic exists; all other behaviour is identical.

Verification
- REQ-033: ACK handshake, bits 0,1,0,0,1,0,1,1, then endr -> done 1 cycle later, pid=4'h2, pkt_type=2, pkt_ok=1, err=0.
- REQ-034: SETUP token, addr=0, endp=0, CRC5=5'b00010 (PID 8'h2D) -> 11 d_valid pulses all 0, pkt_ok=1; flip CRC bit 0 -> err=3'b010.
- REQ-035: DATA0 with 64 payload bits of 8'hA5 pattern and a correct CRC16 -> 64 d_valid bits matching the payload, residue 16'h800D, pkt_ok=1.
- REQ-036: A token truncated after 10 body bits -> err=3'b100, crc_err=0; PID 8'h21 (nibble mismatch) -> pid_err=1.
- REQ-037: pause asserted on every 3rd cycle during a valid DATA0 -> identical verdict and payload to REQ-035.
- REQ-038: A start pulse mid-BODY, and rst_n low mid-BODY -> no done for the aborted packet; the next packet is judged correctly.

Source files
------------

// File: rtl/crc_check_if.sv
// Receive bit stream from the unstuffer into crc_check, and its verdict/payload outputs.
// CRC_ERR_CNT_EN adds the err_cnt signal.
interface crc_check_if;
  logic       s_in;
  logic       start;
  logic       endr;
  logic       pause;
  logic [3:0] pid;
  logic [1:0] pkt_type;
  logic       d_out;
  logic       d_valid;
  logic       done;
  logic       pkt_ok;
  logic [2:0] err;
`ifdef CRC_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  modport slave (
    input  s_in, start, endr, pause,
    output pid, pkt_type, d_out, d_valid, done, pkt_ok, err
`ifdef CRC_ERR_CNT_EN
    , output err_cnt
`endif
  );

  modport master (
    output s_in, start, endr, pause,
    input  pid, pkt_type, d_out, d_valid, done, pkt_ok, err
`ifdef CRC_ERR_CNT_EN
    , input err_cnt
`endif
  );
endinterface

// File: rtl/crc_check.sv
// USB receive checker: PID capture/decode, CRC5/CRC16 residue and length check, payload forwarding.
// d_out/d_valid lag s_in by 1 cycle, done follows endr by 1 cycle; no backpressure, pause stalls; CRC_ERR_CNT_EN adds err_cnt.
module crc_check (
  input logic        clk,
  input logic        rst_n,
  crc_check_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PID, BODY, CHECK} state_t;

  localparam logic [1:0]  TYPE_DATA  = 2'd0;
  localparam logic [1:0]  TYPE_TOKEN = 2'd1;
  localparam logic [1:0]  TYPE_HS    = 2'd2;
  localparam logic [1:0]  TYPE_INV   = 2'd3;
  localparam logic [4:0]  CRC5_POLY  = 5'b00101;
  localparam logic [4:0]  CRC5_RES   = 5'b01100;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

  state_t      state_q, state_d;
  logic [7:0]  pid_sr_q, pid_sr_d;
  logic [2:0]  pid_cnt_q, pid_cnt_d;
  logic [6:0]  body_cnt_q, body_cnt_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic [2:0]  err_q, err_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic        d_out_q, d_out_d;
  logic        d_valid_q, d_valid_d;

  logic        in_pkt, accept, go_check, done_w;
  logic [1:0]  type_w;
  logic [6:0]  body_len, fwd_len;
  logic        len_err, crc_err, pid_err;
  logic        fb5, fb16;
  logic [4:0]  crc5_nxt;
  logic [15:0] crc16_nxt;

  assign in_pkt   = (state_q == PID) || (state_q == BODY);
  assign accept   = in_pkt && !bus.pause && !bus.endr;
  assign go_check = in_pkt && bus.endr;
  assign done_w   = (state_q == CHECK) && !bus.start;

  always_comb begin
    type_w   = TYPE_INV;
    body_len = 7'd0;
    fwd_len  = 7'd0;
    case (pid_sr_q[1:0])
      2'b01: begin type_w = TYPE_TOKEN; body_len = 7'd16; fwd_len = 7'd11; end
      2'b11: begin type_w = TYPE_DATA;  body_len = 7'd80; fwd_len = 7'd64; end
      2'b10: begin type_w = TYPE_HS; end
      default: ;
    endcase
  end

  // Galois LFSRs shifted MSB-first; a clean packet leaves the fixed residue.
  assign fb5       = crc5_q[4] ^ bus.s_in;
  assign crc5_nxt  = {crc5_q[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'b0);
  assign fb16      = crc16_q[15] ^ bus.s_in;
  assign crc16_nxt = {crc16_q[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'b0);

  assign len_err = (body_cnt_q != body_len);
  assign pid_err = (pid_sr_q[7:4] != ~pid_sr_q[3:0]) || (type_w == TYPE_INV);

  always_comb begin
    crc_err = 1'b0;
    if (!len_err) begin
      if (type_w == TYPE_TOKEN)     crc_err = (crc5_q != CRC5_RES);
      else if (type_w == TYPE_DATA) crc_err = (crc16_q != CRC16_RES);
    end
  end

  always_comb begin
    state_d    = state_q;
    pid_sr_d   = pid_sr_q;
    pid_cnt_d  = pid_cnt_q;
    body_cnt_d = body_cnt_q;
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
    err_d      = err_q;
    pkt_ok_d   = pkt_ok_q;
    d_out_d    = 1'b0;
    d_valid_d  = 1'b0;
    case (state_q)
      PID: begin
        if (accept) begin
          pid_sr_d[pid_cnt_q] = bus.s_in;
          pid_cnt_d           = pid_cnt_q + 3'd1;
          if (pid_cnt_q == 3'd7) begin
            state_d    = BODY;
            crc5_d     = '1;
            crc16_d    = '1;
            body_cnt_d = '0;
          end
        end
      end
      BODY: begin
        if (accept) begin
          if (body_cnt_q != 7'd127) body_cnt_d = body_cnt_q + 7'd1;
          if (type_w == TYPE_TOKEN) crc5_d = crc5_nxt;
          if (type_w == TYPE_DATA)  crc16_d = crc16_nxt;
          if (body_cnt_q < fwd_len) begin
            d_valid_d = 1'b1;
            d_out_d   = bus.s_in;
          end
        end
      end
      CHECK:   state_d = IDLE;
      default: ;
    endcase
    if (go_check) begin
      state_d  = CHECK;
      err_d    = {len_err, crc_err, pid_err};
      pkt_ok_d = !(len_err || crc_err || pid_err);
    end
    // A start anywhere abandons the packet in flight and takes this cycle's bit as PID bit 0.
    if (bus.start) begin
      state_d    = PID;
      pid_sr_d   = {7'b0, bus.s_in};
      pid_cnt_d  = 3'd1;
      body_cnt_d = '0;
      err_d      = '0;
      pkt_ok_d   = 1'b0;
      d_out_d    = 1'b0;
      d_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pid_sr_q   <= '0;
      pid_cnt_q  <= '0;
      body_cnt_q <= '0;
      crc5_q     <= '0;
      crc16_q    <= '0;
      err_q      <= '0;
      pkt_ok_q   <= 1'b0;
      d_out_q    <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_sr_q   <= pid_sr_d;
      pid_cnt_q  <= pid_cnt_d;
      body_cnt_q <= body_cnt_d;
      crc5_q     <= crc5_d;
      crc16_q    <= crc16_d;
      err_q      <= err_d;
      pkt_ok_q   <= pkt_ok_d;
      d_out_q    <= d_out_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign bus.pid      = pid_sr_q[3:0];
  assign bus.pkt_type = type_w;
  assign bus.d_out    = d_out_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.done     = done_w;
  assign bus.pkt_ok   = pkt_ok_q;
  assign bus.err      = err_q;

`ifdef CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (done_w && !pkt_ok_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_crc_check.sv
// Randomized bench for crc_check against a polynomial-division reference model.
module tb_crc_check;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc_check_if bus ();
  crc_check dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int done_at = 0;
  int endr_at = 0;
  logic [2:0]   d_err;
  logic         d_ok;
  logic [3:0]   d_pid;
  logic [1:0]   d_type;
  bit           rx_q[$];
  logic [255:0] bodyv;
`ifdef CRC_ERR_CNT_EN
  int exp_ecnt = 0;
`endif

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.d_valid) rx_q.push_back(bus.d_out);
    if (bus.done) begin
      done_cnt++;
      done_at = cyc_cnt;
      d_err   = bus.err;
      d_ok    = bus.pkt_ok;
      d_pid   = bus.pid;
      d_type  = bus.pkt_type;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Remainder of the message (first w bits complemented, i.e. register preset to ones) times x^w.
  function automatic logic [15:0] crc_rem(input logic [255:0] m, input int n, input int w);
    logic [271:0] a;
    logic [16:0]  g;
    logic [15:0]  r;
    g = (w == 5) ? 17'h00025 : 17'h18005;
    a = '0;
    for (int i = 0; i < n; i++) a[i] = m[i] ^ (i < w);
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ g[w-j];
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = a[n+k];
    return r;
  endfunction

  task automatic mk_token(input logic [10:0] f);
    logic [15:0] r;
    bodyv = '0;
    for (int k = 0; k < 11; k++) bodyv[k] = f[k];
    r = crc_rem(bodyv, 11, 5);
    for (int k = 0; k < 5; k++) bodyv[11+k] = ~r[4-k];
  endtask

  task automatic mk_data(input logic [63:0] p);
    logic [15:0] r;
    bodyv = '0;
    for (int k = 0; k < 64; k++) bodyv[k] = p[k];
    r = crc_rem(bodyv, 64, 16);
    for (int k = 0; k < 16; k++) bodyv[64+k] = ~r[15-k];
  endtask

  task automatic cyc(input logic s, input logic st, input logic en, input logic pa);
    bus.s_in  = s;
    bus.start = st;
    bus.endr  = en;
    bus.pause = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pidb, input int blen, input int pmod, input bit do_endr);
    int ci;
    logic b;
    ci = 0;
    for (int i = 0; i < 8 + blen; i++) begin
      b = (i < 8) ? pidb[i] : bodyv[i-8];
      if (i > 0 && pmod > 0 && (ci % pmod) == pmod - 1) begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        ci++;
      end
      cyc(b, i == 0, 1'b0, 1'b0);
      ci++;
    end
    if (do_endr) begin
      endr_at = cyc_cnt;
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic judge(input string tag, input logic [7:0] pidb, input int blen,
                       input int dbase, input int rbase);
    logic [1:0]  et;
    int          elen, efwd, w, n, nf, nrx;
    logic        perr, lerr, cerr;
    logic [15:0] r;
    logic [2:0]  eerr;
    logic [63:0] ep, ap;
    case (pidb[1:0])
      2'b01:   begin et = 2'd1; elen = 16; efwd = 11; w = 5;  end
      2'b11:   begin et = 2'd0; elen = 80; efwd = 64; w = 16; end
      2'b10:   begin et = 2'd2; elen = 0;  efwd = 0;  w = 0;  end
      default: begin et = 2'd3; elen = 0;  efwd = 0;  w = 0;  end
    endcase
    perr = (pidb[7:4] != ~pidb[3:0]) || (et == 2'd3);
    lerr = (blen != elen);
    cerr = 1'b0;
    if (!lerr && w > 0) begin
      n = elen - w;
      r = crc_rem(bodyv, n, w);
      for (int k = 0; k < w; k++) if (bodyv[n+k] == r[w-1-k]) cerr = 1'b1;
    end
    eerr = {lerr, cerr, perr};
    nf   = (blen < efwd) ? blen : efwd;
    nrx  = rx_q.size() - rbase;
    ep   = '0;
    ap   = '0;
    for (int k = 0; k < nf; k++) ep[k] = bodyv[k];
    for (int k = 0; k < nrx && k < 64; k++) ap[k] = rx_q[rbase+k];
    chk({tag, ".done_cnt"}, 64'(done_cnt - dbase), 64'd1);
    chk({tag, ".done_lat"}, 64'(done_at - endr_at), 64'd1);
    chk({tag, ".err"}, 64'(d_err), 64'(eerr));
    chk({tag, ".pkt_ok"}, 64'(d_ok), 64'(eerr == 3'b000));
    chk({tag, ".pid"}, 64'(d_pid), 64'(pidb[3:0]));
    chk({tag, ".pkt_type"}, 64'(d_type), 64'(et));
    chk({tag, ".type_hold"}, 64'(bus.pkt_type), 64'(et));
    chk({tag, ".n_payload"}, 64'(nrx), 64'(nf));
    chk({tag, ".payload"}, ap, ep);
`ifdef CRC_ERR_CNT_EN
    if (eerr != 3'b000 && exp_ecnt < 255) exp_ecnt++;
`endif
  endtask

  task automatic run(input string tag, input logic [7:0] pidb, input int blen, input int pmod);
    int dbase, rbase;
    dbase = done_cnt;
    rbase = rx_q.size();
    send(pidb, blen, pmod, 1'b1);
    judge(tag, pidb, blen, dbase, rbase);
  endtask

  initial begin
    int          kind, pm, bl, dbase, sel;
    logic [3:0]  nib;
    logic [7:0]  pb;
    rst_n     = 1'b0;
    bus.s_in  = 1'b0;
    bus.start = 1'b0;
    bus.endr  = 1'b0;
    bus.pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pid", 64'(bus.pid), 64'd0);
    chk("rst.pkt_type", 64'(bus.pkt_type), 64'd3);
    chk("rst.d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst.d_out", 64'(bus.d_out), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.pkt_ok", 64'(bus.pkt_ok), 64'd0);
    chk("rst.err", 64'(bus.err), 64'd0);
`ifdef CRC_ERR_CNT_EN
    chk("rst.err_cnt", 64'(bus.err_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("idle_endr.done_cnt", 64'(done_cnt), 64'd0);

    bodyv = '0;
    run("ack", 8'hD2, 0, 0);
    mk_token(11'h000);
    run("setup", 8'h2D, 16, 0);
    bodyv[11] = ~bodyv[11];
    run("setup_badcrc", 8'h2D, 16, 0);
    mk_data({8{8'hA5}});
    run("data0", 8'hC3, 80, 0);
    run("data0_pause", 8'hC3, 80, 3);
    mk_token(11'($urandom));
    run("token_trunc", 8'hE1, 10, 0);
    mk_token(11'($urandom));
    run("pid_bad", 8'h21, 16, 0);
    mk_data({$urandom, $urandom});
    for (int k = 80; k < 208; k++) bodyv[k] = 1'($urandom_range(0, 1));
    run("data_long", 8'hC3, 208, 0);

    mk_data({$urandom, $urandom});
    send(8'hC3, 40, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    mk_token(11'($urandom));
    run("abort_start", 8'h69, 16, 0);

    mk_data({$urandom, $urandom});
    send(8'h4B, 50, 0, 1'b0);
    dbase = done_cnt;
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.pkt_type", 64'(bus.pkt_type), 64'd3);
    chk("midrst.d_valid", 64'(bus.d_valid), 64'd0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.no_done", 64'(done_cnt - dbase), 64'd0);
    mk_data({$urandom, $urandom});
    run("after_rst", 8'h4B, 80, 0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      pm   = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 5) : 0;
      case (kind)
        0: begin nib = {2'($urandom), 2'b01}; mk_token(11'($urandom)); bl = 16; end
        1: begin nib = {2'($urandom), 2'b11}; mk_data({$urandom, $urandom}); bl = 80; end
        default: begin nib = {2'($urandom), 2'b10}; bodyv = {8{$urandom}}; bl = 0; end
      endcase
      pb  = {~nib, nib};
      sel = $urandom_range(0, 9);
      if (sel == 0) pb[4 + $urandom_range(0, 3)] = ~pb[4 + $urandom_range(0, 3)];
      else if (sel == 1) bl = $urandom_range(0, bl + 3);
      else if (sel == 2 && bl > 0) begin
        int fi;
        fi = $urandom_range(0, bl - 1);
        bodyv[fi] = ~bodyv[fi];
      end
      run($sformatf("rnd%0d", t), pb, bl, pm);
    end

`ifdef CRC_ERR_CNT_EN
    chk("err_cnt", 64'(bus.err_cnt), 64'(exp_ecnt));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
